hub75_top: RTL and testbench
============================

HUB75_TOP -- requirements
Module: hub75_top

Interface
REQ-001 clk  input  1  single system clock; all logic on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 r1,g1,b1 .. r4,g4,b4  output  1 each  serial colour data for panel channels 1-4.
REQ-004 row_clk  output  1  shift clock for the external row-select shift register.
REQ-005 row_data  output  1  serial data into the row-select shift register.
REQ-006 clk_out  output  1  column shift clock to the panel.
REQ-007 lat  output  1  column latch strobe, active-high.
REQ-008 blank  output  1  output-enable, active-high blank (1 = LEDs off).
REQ-009 Parameters: COLS=64, ROWS=16 scan rows, BITS=4 colour bit planes, BASE=8 display cycles for bit 0.
REQ-010 The block SHALL have no other ports; pixel data SHALL be generated internally.

Function
REQ-011 Counters: col (0..63), row (0..15), plane (0..3), frame (8-bit, wraps 255->0), state cycle counter.
REQ-012 FSM states: ROW_SEL, SHIFT, LATCH, DISPLAY; all outputs SHALL be registered.
REQ-013 ROW_SEL, 2 cycles: cycle 1 row_data=(row==0), row_clk=0; cycle 2 row_clk=1; then -> SHIFT with row_clk=0, plane=0.
REQ-014 SHIFT, 2*COLS=128 cycles: per column, cycle A drives colour bits with clk_out=0; cycle B holds them with clk_out=1; col increments after cycle B; after col 63 -> LATCH.
REQ-015 LATCH, 1 cycle: lat=1, clk_out=0; then -> DISPLAY.
REQ-016 DISPLAY, BASE<<plane cycles (8,16,32,64): blank=0; all other outputs SHALL be 0.
REQ-017 After DISPLAY: plane<3 -> plane+1, SHIFT; plane==3 -> row+1, ROW_SEL; row 15 -> row=0, frame+1, ROW_SEL.
REQ-018 blank SHALL be 1 in every state except DISPLAY; lat SHALL be 1 only in LATCH.
REQ-019 Test pattern, channel k (0..3), 4-bit values: R=col[5:2], G=row[3:0], B=frame[7:4]^k; the output bit is value[plane].
REQ-020 Colour outputs SHALL be 0 outside SHIFT.
REQ-021 Row period SHALL be 2 + 4*(128+1) + 120 = 638 cycles; frame period 16*638 = 10208 cycles.
REQ-022 Only the ROW_SEL of row 0 SHALL drive row_data=1, so a single one-hot bit walks through the external register.

Reset
REQ-023 While rst=0: all colour outputs, row_clk, row_data, clk_out and lat = 0; blank = 1.
REQ-024 While rst=0: state=ROW_SEL cycle 1; col, row, plane and frame = 0.
REQ-025 Reset asserted mid-operation SHALL abort immediately to the REQ-023/REQ-024 values.
REQ-026 After rst rises, the first clock edge SHALL begin ROW_SEL cycle 1 for row 0.

Verification
REQ-027 Release reset, count cycles -> first row_clk rising after 1-2 cycles with row_data=1; next row_clk rise exactly 638 cycles later with row_data=0.
REQ-028 Count clk_out rising edges between consecutive lat pulses -> exactly 64; lat pulse width = 1 cycle.
REQ-029 Measure blank-low widths after successive lat pulses in row 0 -> 8, 16, 32, 64 cycles, then repeating.
REQ-030 Frame 0, row 0, plane 3 shift -> r1..r4 = 1 exactly for columns 32..63; g1..g4 = 0 throughout; b2 = 0, b3 = 0, b4 = 0 (frame[7:4]=0, k=1,2,3 -> bit 3 = 0).
REQ-031 Invariants over 150000 cycles: lat and blank=0 never overlap; clk_out never toggles during DISPLAY; row_data=1 once per 10208 cycles.
REQ-032 Assert rst=0 mid-SHIFT -> outputs return to reset values asynchronously; after release the sequence restarts at row 0, plane 0.

Source files
------------

// File: rtl/hub75_top.sv
// HUB75 panel scan driver for four channels with a built-in test pattern.
// Rows are selected by walking a single one through an external shift register; colour depth comes from binary-weighted bit planes.
module hub75_top #(
   parameter int COLS = 64,
   parameter int ROWS = 16,
   parameter int BITS = 4,
   parameter int BASE = 8
) (
   input  logic clk,
   input  logic rst,
   output logic r1,
   output logic g1,
   output logic b1,
   output logic r2,
   output logic g2,
   output logic b2,
   output logic r3,
   output logic g3,
   output logic b3,
   output logic r4,
   output logic g4,
   output logic b4,
   output logic row_clk,
   output logic row_data,
   output logic clk_out,
   output logic lat,
   output logic blank
);

   localparam int CLW = $clog2(COLS);
   localparam int RW  = $clog2(ROWS);
   localparam int PW  = $clog2(BITS);
   localparam int CW  = $clog2(BASE << BITS);

   typedef enum logic [1:0] {ROW_SEL, SHIFT, LATCH, DISPLAY} state_t;

   state_t         state_reg, state_next;
   logic [CLW-1:0] col_reg, col_next;
   logic [RW-1:0]  row_reg, row_next;
   logic [PW-1:0]  plane_reg, plane_next;
   logic [7:0]     frame_reg, frame_next;
   logic [CW-1:0]  cyc_reg, cyc_next;
   logic           phase_reg, phase_next;

   logic [3:0] r_reg, r_next, g_reg, g_next, b_reg, b_next;
   logic       row_clk_reg, row_clk_next, row_data_reg, row_data_next;
   logic       clk_out_reg, clk_out_next, lat_reg, lat_next, blank_reg, blank_next;

   logic [3:0]    r_val, g_val;
   logic          r_pat, g_pat;
   logic [3:0]    b_pat;
   logic [CW-1:0] disp_last;

   assign r_val = col_reg[5:2];
   assign g_val = row_reg[3:0];
   assign r_pat = r_val[plane_reg];
   assign g_pat = g_val[plane_reg];
   assign disp_last = CW'((BASE << plane_reg) - 1);

   // Blue differs per channel: the frame's high nibble XOR the channel index.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_blue
         logic [3:0] b_val;
         assign b_val     = frame_reg[7:4] ^ 4'(gi);
         assign b_pat[gi] = b_val[plane_reg];
      end
   endgenerate

   // Outputs are computed from the current state and registered, so pins lag the state register by one clock.
   always_comb begin
      state_next    = state_reg;
      col_next      = col_reg;
      row_next      = row_reg;
      plane_next    = plane_reg;
      frame_next    = frame_reg;
      cyc_next      = cyc_reg;
      phase_next    = phase_reg;
      r_next        = '0;
      g_next        = '0;
      b_next        = '0;
      row_clk_next  = 1'b0;
      row_data_next = 1'b0;
      clk_out_next  = 1'b0;
      lat_next      = 1'b0;
      blank_next    = 1'b1;
      case (state_reg)
         ROW_SEL: begin
            row_data_next = (row_reg == '0);
            row_clk_next  = (cyc_reg == CW'(1));
            if (cyc_reg == CW'(1)) begin
               state_next = SHIFT;
               cyc_next   = '0;
               plane_next = '0;
               col_next   = '0;
               phase_next = 1'b0;
            end else begin
               cyc_next = cyc_reg + CW'(1);
            end
         end
         SHIFT: begin
            r_next       = {4{r_pat}};
            g_next       = {4{g_pat}};
            b_next       = b_pat;
            clk_out_next = phase_reg;
            phase_next   = ~phase_reg;
            if (phase_reg) begin
               if (col_reg == CLW'(COLS - 1)) begin
                  col_next   = '0;
                  state_next = LATCH;
               end else begin
                  col_next = col_reg + CLW'(1);
               end
            end
         end
         LATCH: begin
            lat_next   = 1'b1;
            cyc_next   = '0;
            state_next = DISPLAY;
         end
         DISPLAY: begin
            blank_next = 1'b0;
            if (cyc_reg == disp_last) begin
               cyc_next   = '0;
               col_next   = '0;
               phase_next = 1'b0;
               if (plane_reg == PW'(BITS - 1)) begin
                  plane_next = '0;
                  state_next = ROW_SEL;
                  if (row_reg == RW'(ROWS - 1)) begin
                     row_next   = '0;
                     frame_next = frame_reg + 8'd1;
                  end else begin
                     row_next = row_reg + RW'(1);
                  end
               end else begin
                  plane_next = plane_reg + PW'(1);
                  state_next = SHIFT;
               end
            end else begin
               cyc_next = cyc_reg + CW'(1);
            end
         end
         default: state_next = ROW_SEL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ROW_SEL;
         col_reg      <= '0;
         row_reg      <= '0;
         plane_reg    <= '0;
         frame_reg    <= '0;
         cyc_reg      <= '0;
         phase_reg    <= 1'b0;
         r_reg        <= '0;
         g_reg        <= '0;
         b_reg        <= '0;
         row_clk_reg  <= 1'b0;
         row_data_reg <= 1'b0;
         clk_out_reg  <= 1'b0;
         lat_reg      <= 1'b0;
         blank_reg    <= 1'b1;
      end else begin
         state_reg    <= state_next;
         col_reg      <= col_next;
         row_reg      <= row_next;
         plane_reg    <= plane_next;
         frame_reg    <= frame_next;
         cyc_reg      <= cyc_next;
         phase_reg    <= phase_next;
         r_reg        <= r_next;
         g_reg        <= g_next;
         b_reg        <= b_next;
         row_clk_reg  <= row_clk_next;
         row_data_reg <= row_data_next;
         clk_out_reg  <= clk_out_next;
         lat_reg      <= lat_next;
         blank_reg    <= blank_next;
      end
   end

   assign {r4, r3, r2, r1} = r_reg;
   assign {g4, g3, g2, g1} = g_reg;
   assign {b4, b3, b2, b1} = b_reg;
   assign row_clk  = row_clk_reg;
   assign row_data = row_data_reg;
   assign clk_out  = clk_out_reg;
   assign lat      = lat_reg;
   assign blank    = blank_reg;

endmodule

// File: tb/tb_hub75_top.sv
// Self-checking bench for hub75_top: every output is compared each cycle against a timeline model derived from the scan period arithmetic.
module tb_hub75_top;

   localparam int ROW_P   = 638;
   localparam int FRAME_P = 10208;
   localparam logic [16:0] RESET_VEC = 17'h00001;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic r1, g1, b1, r2, g2, b2, r3, g3, b3, r4, g4, b4;
   logic row_clk, row_data, clk_out, lat, blank;

   int checks = 0;
   int errors = 0;

   hub75_top dut (
      .clk(clk), .rst(rst),
      .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
      .r3(r3), .g3(g3), .b3(b3), .r4(r4), .g4(g4), .b4(b4),
      .row_clk(row_clk), .row_data(row_data), .clk_out(clk_out),
      .lat(lat), .blank(blank)
   );

   always #5 clk = ~clk;

   // Vector layout: [16:13] r4..r1, [12:9] g4..g1, [8:5] b4..b1, [4] row_clk, [3] row_data, [2] clk_out, [1] lat, [0] blank
   function automatic logic [16:0] dut_vec();
      return {r4, r3, r2, r1, g4, g3, g2, g1, b4, b3, b2, b1,
              row_clk, row_data, clk_out, lat, blank};
   endfunction

   // Expected outputs t cycles after the first edge following reset release.
   function automatic logic [16:0] model(input int t);
      logic [16:0] v;
      int fr, rem, row, c, col, len;
      v    = '0;
      v[0] = 1'b1;
      fr   = (t / FRAME_P) % 256;
      rem  = t % FRAME_P;
      row  = rem / ROW_P;
      c    = rem % ROW_P;
      if (c < 2) begin
         v[3] = (row == 0);
         v[4] = (c == 1);
      end else begin
         c = c - 2;
         for (int p = 0; p < 4; p++) begin
            len = 129 + (8 << p);
            if (c >= 0 && c < len) begin
               if (c < 128) begin
                  col  = c / 2;
                  v[2] = ((c % 2) == 1);
                  for (int k = 0; k < 4; k++) begin
                     v[13 + k] = (((col >> 2) >> p) & 1) != 0;
                     v[9 + k]  = ((row >> p) & 1) != 0;
                     v[5 + k]  = ((((fr >> 4) ^ k) >> p) & 1) != 0;
                  end
               end else if (c == 128) begin
                  v[1] = 1'b1;
               end else begin
                  v[0] = 1'b0;
               end
            end
            c = c - len;
         end
      end
      return v;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b0;
      n = $urandom_range(3, 10);
      for (int i = 0; i < n; i++) begin
         step();
         checks++;
         if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %h expected %h", i, dut_vec(), RESET_VEC);
         end
      end
      $display("test_reset: held %0d cycles", n);
   endtask

   task automatic test_frame();
      logic [16:0] got, exp_v, prev;
      int loc_err, nrise, first_t, ck_cnt, lat_len, low_run, nwin, rd_rises;
      bit seen_lat;
      loc_err = 0; nrise = 0; first_t = 0; ck_cnt = 0; lat_len = 0;
      low_run = 0; nwin = 0; rd_rises = 0; seen_lat = 0;
      prev = RESET_VEC;
      rst = 1'b1;
      for (int t = 0; t < FRAME_P + 2 * ROW_P; t++) begin
         step();
         got   = dut_vec();
         exp_v = model(t);
         checks++;
         if (got !== exp_v) begin
            errors++;
            loc_err++;
            $display("FAIL frame_scan t=%0d: got %h expected %h", t, got, exp_v);
         end
         if (got[4] && !prev[4]) begin
            nrise++;
            if (nrise == 1) begin
               first_t = t;
               checks++;
               if (t > 1 || got[3] !== 1'b1) begin
                  errors++;
                  $display("FAIL first_row_clk: rise at edge %0d row_data %b, expected edge 1..2 row_data 1", t + 1, got[3]);
               end
            end else if (nrise == 2) begin
               checks++;
               if ((t - first_t) != ROW_P || got[3] !== 1'b0) begin
                  errors++;
                  $display("FAIL row_period: %0d cycles row_data %b, expected %0d row_data 0", t - first_t, got[3], ROW_P);
               end
            end
         end
         if (got[3] && !prev[3]) rd_rises++;
         if (got[2] && !prev[2]) ck_cnt++;
         if (got[1]) lat_len++;
         if (got[1] && !prev[1]) begin
            if (seen_lat) begin
               checks++;
               if (ck_cnt != 64) begin
                  errors++;
                  $display("FAIL clk_out_per_latch t=%0d: got %0d expected 64", t, ck_cnt);
               end
            end
            seen_lat = 1;
            ck_cnt = 0;
         end
         if (!got[1] && prev[1]) begin
            checks++;
            if (lat_len != 1) begin
               errors++;
               $display("FAIL lat_width t=%0d: got %0d expected 1", t, lat_len);
            end
            lat_len = 0;
         end
         if (!got[0]) begin
            low_run++;
            checks++;
            if (got[1] || got[2]) begin
               errors++;
               $display("FAIL display_quiet t=%0d: lat %b clk_out %b expected 0 0", t, got[1], got[2]);
            end
         end else if (!prev[0]) begin
            checks++;
            if (low_run != (8 << (nwin % 4))) begin
               errors++;
               $display("FAIL blank_width t=%0d: got %0d expected %0d", t, low_run, 8 << (nwin % 4));
            end
            nwin++;
            low_run = 0;
         end
         prev = got;
         if ((t % ROW_P) == ROW_P - 1)
            $display("frame %0d row %0d scanned (t=%0d)", t / FRAME_P, (t % FRAME_P) / ROW_P, t);
         if (loc_err >= 20) break;
      end
      checks++;
      if (rd_rises != 2) begin
         errors++;
         $display("FAIL row_data_once_per_frame: got %0d rises expected 2", rd_rises);
      end
   endtask

   task automatic test_mid_reset();
      int rr, cc, target, loc_err;
      loc_err = 0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      rr = $urandom_range(0, 3);
      cc = $urandom_range(0, 63);
      target = rr * ROW_P + 2 + 2 * cc + 1;
      for (int t = 0; t <= target; t++) begin
         step();
         checks++;
         if (dut_vec() !== model(t)) begin
            errors++;
            loc_err++;
            $display("FAIL pre_abort t=%0d: got %h expected %h", t, dut_vec(), model(t));
         end
         if (loc_err >= 20) break;
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== RESET_VEC) begin
         errors++;
         $display("FAIL async_abort: got %h expected %h", dut_vec(), RESET_VEC);
      end
      $display("test_mid_reset: aborted at row %0d col %0d", rr, cc);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL abort_hold %0d: got %h expected %h", i, dut_vec(), RESET_VEC);
         end
      end
      rst = 1'b1;
      loc_err = 0;
      for (int t = 0; t < ROW_P + 20; t++) begin
         step();
         checks++;
         if (dut_vec() !== model(t)) begin
            errors++;
            loc_err++;
            $display("FAIL restart t=%0d: got %h expected %h", t, dut_vec(), model(t));
         end
         if (loc_err >= 20) break;
      end
   endtask

   task automatic test_back_to_back();
      int n;
      for (int i = 0; i < 4; i++) begin
         rst = 1'b0;
         step();
         checks++;
         if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL b2b_reset %0d: got %h expected %h", i, dut_vec(), RESET_VEC);
         end
         rst = 1'b1;
         n = $urandom_range(1, 200);
         for (int t = 0; t < n; t++) begin
            step();
            checks++;
            if (dut_vec() !== model(t)) begin
               errors++;
               $display("FAIL b2b_run %0d t=%0d: got %h expected %h", i, t, dut_vec(), model(t));
               break;
            end
         end
         $display("test_back_to_back: burst %0d ran %0d cycles", i, n);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_mid_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
